ra_16bit: RTL and testbench
===========================

RA_16BIT -- requirements
Module: ra_16bit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 16 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Ports A0..A15, input, 1 bit each: operand A, two's complement; A0 is the LSB and A15 the sign bit.
REQ-006 Ports B0..B15, input, 1 bit each: operand B, two's complement; B0 is the LSB and B15 the sign bit.
REQ-007 Port SUB, input, 1 bit: operation select; 0 selects A+B, 1 selects A-B.
REQ-008 Ports C0..C15, output, 1 bit each: registered result; C0 is the LSB and C15 the sign bit.
REQ-009 Port OVF, output, 1 bit: registered signed-overflow flag for the same operation as C.

Function
REQ-010 The datapath SHALL be a ripple chain of 16 one-bit full-adder cells; cell i adds A[i], B[i] XOR SUB and carry-in c[i].
REQ-011 The carry-in c[0] SHALL equal SUB, so subtraction is computed as A + ~B + 1.
REQ-012 Carry c[i+1] SHALL equal carry-out of cell i; the carry-out of cell 15 SHALL be internal only and SHALL NOT be a port.
REQ-013 Each full-adder cell SHALL compute sum = a^b^cin and cout = (a&b)|(a&cin)|(b&cin).
REQ-014 The combinational result SHALL be (A + (B XOR {16{SUB}}) + SUB) mod 2^16.
REQ-015 The overflow term SHALL be c[15] XOR c[16], the carry into the MSB XOR the carry out of the MSB.
REQ-016 On each rising clk edge with rst_n high, C0..C15 and OVF SHALL load the combinational result and overflow term computed from the A, B and SUB values present at that edge.
REQ-017 Latency SHALL be exactly 1 cycle, with one new result per cycle and no handshake or stall.
REQ-018 Outputs SHALL hold their value between edges and SHALL NOT change combinationally with the inputs.
REQ-019 Wrap-around: a result outside [-32768, 32767] SHALL be truncated to 16 bits, with OVF=1.
REQ-020 Boundary: 0 - (-32768) SHALL give C=0x8000, OVF=1; -32768 - 1 SHALL give C=0x7FFF, OVF=1.
REQ-021 Unsigned carry or borrow alone SHALL NOT set OVF; for example, -1 + 1 SHALL give C=0x0000, OVF=0.

Reset
REQ-022 While rst_n is low, C0..C15 SHALL be 0 and OVF SHALL be 0, asynchronously and independent of clk.
REQ-023 Asserting rst_n mid-stream SHALL discard the pending result; the first edge after rst_n deasserts SHALL load the result for the inputs present at that edge.
REQ-024 Reset SHALL NOT depend on any input other than rst_n.

Verification
REQ-025 SUB=0, A=-18966 (0xB5EA), B=9483 (0x250B) -> next cycle C=0xDAF5 (-9483), OVF=0.
REQ-026 SUB=0, A=153, B=-247 -> C=0xFFA2 (-94), OVF=0.
REQ-027 SUB=1, A=-18966, B=-6 -> C=0xB5F0 (-18960), OVF=0; and SUB=1, A=256, B=350 -> C=0xFFA2 (-94), OVF=0.
REQ-028 SUB=0, A=32767, B=32767 -> C=0xFFFE, OVF=1; and SUB=1, A=0, B=-32768 -> C=0x8000, OVF=1.
REQ-029 Drive rst_n low asynchronously between clock edges while C is nonzero -> C=0 and OVF=0 immediately; release rst_n -> first valid result appears one edge later.
REQ-030 Randomized check: at least 10,000 random A, B, SUB vectors against a reference model of REQ-014 and REQ-015, with a one-cycle-delayed compare.

Source files
------------

// File: rtl/ra_16bit.sv
// 16-bit ripple-carry add/subtract unit with a registered result and
// signed-overflow flag; one result per clock, one cycle of latency.

module ra_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module ra_16bit (
    input  logic clk,
    input  logic rst_n,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic A6,
    input  logic A7,
    input  logic A8,
    input  logic A9,
    input  logic A10,
    input  logic A11,
    input  logic A12,
    input  logic A13,
    input  logic A14,
    input  logic A15,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic B4,
    input  logic B5,
    input  logic B6,
    input  logic B7,
    input  logic B8,
    input  logic B9,
    input  logic B10,
    input  logic B11,
    input  logic B12,
    input  logic B13,
    input  logic B14,
    input  logic B15,
    input  logic SUB,
    output logic C0,
    output logic C1,
    output logic C2,
    output logic C3,
    output logic C4,
    output logic C5,
    output logic C6,
    output logic C7,
    output logic C8,
    output logic C9,
    output logic C10,
    output logic C11,
    output logic C12,
    output logic C13,
    output logic C14,
    output logic C15,
    output logic OVF
);

    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] b_eff;
    logic [15:0] sum;
    logic [16:0] carry;
    logic [15:0] c_q;
    logic        ovf_q;

    assign a = {A15, A14, A13, A12, A11, A10, A9, A8,
                A7, A6, A5, A4, A3, A2, A1, A0};
    assign b = {B15, B14, B13, B12, B11, B10, B9, B8,
                B7, B6, B5, B4, B3, B2, B1, B0};

    // Subtract is A + ~B + 1: invert B and inject SUB as carry-in.
    assign b_eff    = b ^ {16{SUB}};
    assign carry[0] = SUB;

    for (genvar i = 0; i < 16; i++) begin : g_cell
        ra_fa_cell u_cell (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q   <= 16'h0000;
            ovf_q <= 1'b0;
        end else begin
            c_q   <= sum;
            ovf_q <= carry[15] ^ carry[16];
        end
    end

    assign {C15, C14, C13, C12, C11, C10, C9, C8,
            C7, C6, C5, C4, C3, C2, C1, C0} = c_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_ra_16bit.sv
// Scoreboard bench for ra_16bit: stimulus pushes expected results,
// a monitor pops and compares one cycle after each edge.

module tb_ra_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        sub = 1'b0;
    logic [15:0] c;
    logic        ovf;

    int n_vec = 0;
    int n_bad = 0;

    logic [16:0] exp_q[$];
    logic [16:0] hold_exp = 17'h0;
    logic        hold_ok = 1'b0;

    always #5 clk = ~clk;

    ra_16bit dut (
        .clk(clk), .rst_n(rst_n),
        .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
        .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
        .A8(a[8]), .A9(a[9]), .A10(a[10]), .A11(a[11]),
        .A12(a[12]), .A13(a[13]), .A14(a[14]), .A15(a[15]),
        .B0(b[0]), .B1(b[1]), .B2(b[2]), .B3(b[3]),
        .B4(b[4]), .B5(b[5]), .B6(b[6]), .B7(b[7]),
        .B8(b[8]), .B9(b[9]), .B10(b[10]), .B11(b[11]),
        .B12(b[12]), .B13(b[13]), .B14(b[14]), .B15(b[15]),
        .SUB(sub),
        .C0(c[0]), .C1(c[1]), .C2(c[2]), .C3(c[3]),
        .C4(c[4]), .C5(c[5]), .C6(c[6]), .C7(c[7]),
        .C8(c[8]), .C9(c[9]), .C10(c[10]), .C11(c[11]),
        .C12(c[12]), .C13(c[13]), .C14(c[14]), .C15(c[15]),
        .OVF(ovf)
    );

    task automatic check(input string name, input logic [16:0] act,
                         input logic [16:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got C=%h OVF=%b, want C=%h OVF=%b",
                     name, act[15:0], act[16], want[15:0], want[16]);
        end
    endtask

    task automatic push_vec(input logic [15:0] va, input logic [15:0] vb,
                            input logic vs, input logic [15:0] ec,
                            input logic eo);
        a   = va;
        b   = vb;
        sub = vs;
        exp_q.push_back({eo, ec});
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                         input logic vs, input logic [15:0] ec,
                         input logic eo);
        @(negedge clk);
        push_vec(va, vb, vs, ec, eo);
    endtask

    // Independent integer model of signed add/subtract with range check.
    task automatic drive_model(input logic [15:0] va, input logic [15:0] vb,
                               input logic vs);
        int r;
        logic [31:0] rv;
        r  = vs ? (int'($signed(va)) - int'($signed(vb)))
                : (int'($signed(va)) + int'($signed(vb)));
        rv = r;
        drive(va, vb, vs, rv[15:0], (r > 32767) || (r < -32768));
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("result", {ovf, c}, e);
            hold_exp = e;
            hold_ok  = 1'b1;
        end
    end

    // Outputs must not follow input changes made at the falling edge.
    always @(negedge clk) begin
        #2;
        if (hold_ok && rst_n)
            check("hold", {ovf, c}, hold_exp);
    end

    initial begin
        #1;
        check("reset_state", {ovf, c}, 17'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(16'hB5EA, 16'h250B, 1'b0, 16'hDAF5, 1'b0);
        drive(16'h0099, 16'hFF09, 1'b0, 16'hFFA2, 1'b0);
        drive(16'hB5EA, 16'hFFFA, 1'b1, 16'hB5F0, 1'b0);
        drive(16'h0100, 16'h015E, 1'b1, 16'hFFA2, 1'b0);
        drive(16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b1);
        drive(16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1);
        drive(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);
        drive(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
        drive(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        drive(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0);
        drive(16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1);
        drive(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

        // Mid-stream async reset while C is nonzero; pending result dropped.
        drive(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        drive(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);
        @(posedge clk);
        #3;
        hold_ok = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset", {ovf, c}, 17'h0);
        @(posedge clk);
        #2;
        check("reset_held", {ovf, c}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push_vec(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b1);
        drive(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0);

        for (int i = 0; i < 10000; i++)
            drive_model(16'($urandom), 16'($urandom), 1'($urandom));

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d results pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
